mem_access_stage: RTL and testbench

- MEM stage of the 5-stage CPU. Sits directly downstream of the EX/MEM pipeline register and consumes its MEM_* outputs.
- Performs the data-memory load/store over a req/ack bus and selects the writeback value.
- Registers the result into the MEM/WB boundary.
- Stalls the upstream pipeline while a memory access is outstanding. Bounds each access with a timeout.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/mem_wb_pipeline.sv | 45 ++++
 rtl/mem_access_stage.sv | 128 ++++++++++++
 tb/tb_mem_access_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the MEM-stage access state encoding.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int PC_W   = 22;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // Return PCs are narrower than the datapath and are zero-extended for writeback.
    function automatic logic [DATA_W-1:0] pc_to_data(input logic [PC_W-1:0] pc);
        return {{(DATA_W-PC_W){1'b0}}, pc};
    endfunction

endpackage

// File: rtl/mem_wb_pipeline.sv
// MEM/WB boundary register. A bubble clears the control bits and holds the payload.
module mem_wb_pipeline
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              bubble_i,
    input  logic              we_i,
    input  logic [REG_W-1:0]  dst_reg_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              hlt_i,
    output logic              we_o,
    output logic [REG_W-1:0]  dst_reg_o,
    output logic [DATA_W-1:0] data_o,
    output logic              hlt_o
);

    logic              we_q;
    logic [REG_W-1:0]  dst_reg_q;
    logic [DATA_W-1:0] data_q;
    logic              hlt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q      <= 1'b0;
            dst_reg_q <= '0;
            data_q    <= '0;
            hlt_q     <= 1'b0;
        end else if (bubble_i) begin
            we_q  <= 1'b0;
            hlt_q <= 1'b0;
        end else begin
            we_q      <= we_i;
            dst_reg_q <= dst_reg_i;
            data_q    <= data_i;
            hlt_q     <= hlt_i;
        end
    end

    assign we_o      = we_q;
    assign dst_reg_o = dst_reg_q;
    assign data_o    = data_q;
    assign hlt_o     = hlt_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: req/ack data-memory access with a bounded wait, writeback select,
// upstream stall generation and halt latching, feeding the MEM/WB register.
module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_mem_we,
    input  logic              MEM_wb_mem_sel,
    input  logic              MEM_wb_pc_sel,
    input  logic              MEM_wb_we,
    input  logic              MEM_wb_mov_sel,
    input  logic              MEM_hlt,
    input  logic [REG_W-1:0]  MEM_dst_reg,
    input  logic [DATA_W-1:0] MEM_mov_data,
    input  logic [DATA_W-1:0] MEM_alu_data,
    input  logic [DATA_W-1:0] MEM_sw_data,
    input  logic [PC_W-1:0]   MEM_wb_pc_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              mem_stall,
    output logic              WB_we,
    output logic [REG_W-1:0]  WB_dst_reg,
    output logic [DATA_W-1:0] WB_data,
    output logic              WB_hlt,
    output logic              bus_err
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    mem_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              halted_q;
    logic              bus_err_q;

    logic              mem_op;
    logic              req_raw;
    logic              ack_valid;
    logic              timeout_hit;
    logic              wb_we_d;
    logic              wb_hlt_d;
    logic [DATA_W-1:0] wb_data_d;

    assign mem_op      = (MEM_mem_we | MEM_wb_mem_sel) & ~halted_q;
    assign req_raw     = ((state_q == IDLE) & mem_op) | (state_q == WAIT);
    // Gating with rst drops the request the moment reset arrives, not at the next edge.
    assign dmem_req    = req_raw & ~rst;
    assign dmem_we     = MEM_mem_we;
    assign dmem_addr   = MEM_alu_data[ADDR_W-1:0];
    assign dmem_wdata  = MEM_sw_data;

    assign ack_valid   = dmem_req & dmem_ack;
    assign timeout_hit = (state_q == WAIT) & (cnt_q == CNT_LAST);
    assign mem_stall   = dmem_req & ~dmem_ack & ~timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            halted_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_op && !dmem_ack) begin
                        state_q <= WAIT;
                        cnt_q   <= '0;
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        state_q <= IDLE;
                    end else if (timeout_hit) begin
                        state_q   <= IDLE;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
            // A halt is only taken once its instruction leaves the stage.
            if (MEM_hlt && !mem_stall && !halted_q) begin
                halted_q <= 1'b1;
            end
        end
    end

    // Aborted or suppressed loads write back zero instead of stale bus data.
    always_comb begin
        wb_data_d = MEM_alu_data;
        if (MEM_wb_mem_sel) begin
            wb_data_d = ack_valid ? dmem_rdata : '0;
        end else if (MEM_wb_mov_sel) begin
            wb_data_d = MEM_mov_data;
        end else if (MEM_wb_pc_sel) begin
            wb_data_d = pc_to_data(MEM_wb_pc_data);
        end
    end

    assign wb_we_d  = MEM_wb_we & ~halted_q;
    assign wb_hlt_d = MEM_hlt & ~halted_q;

    mem_wb_pipeline u_mem_wb (
        .clk       (clk),
        .rst       (rst),
        .bubble_i  (mem_stall),
        .we_i      (wb_we_d),
        .dst_reg_i (MEM_dst_reg),
        .data_i    (wb_data_d),
        .hlt_i     (wb_hlt_d),
        .we_o      (WB_we),
        .dst_reg_o (WB_dst_reg),
        .data_o    (WB_data),
        .hlt_o     (WB_hlt)
    );

    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: single-cycle vector table plus hand-written
// multi-cycle sequences, with a writeback scoreboard queue.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_mem_we, MEM_wb_mem_sel, MEM_wb_pc_sel, MEM_wb_we, MEM_wb_mov_sel, MEM_hlt;
    logic [4:0]  MEM_dst_reg;
    logic [31:0] MEM_mov_data, MEM_alu_data, MEM_sw_data;
    logic [21:0] MEM_wb_pc_data;
    logic        dmem_req, dmem_we;
    logic [15:0] dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        mem_stall;
    logic        WB_we;
    logic [4:0]  WB_dst_reg;
    logic [31:0] WB_data;
    logic        WB_hlt;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(16), .TIMEOUT_CYC(15)) dut (
        .clk(clk), .rst(rst),
        .MEM_mem_we(MEM_mem_we), .MEM_wb_mem_sel(MEM_wb_mem_sel), .MEM_wb_pc_sel(MEM_wb_pc_sel),
        .MEM_wb_we(MEM_wb_we), .MEM_wb_mov_sel(MEM_wb_mov_sel), .MEM_hlt(MEM_hlt),
        .MEM_dst_reg(MEM_dst_reg), .MEM_mov_data(MEM_mov_data), .MEM_alu_data(MEM_alu_data),
        .MEM_sw_data(MEM_sw_data), .MEM_wb_pc_data(MEM_wb_pc_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_stall(mem_stall),
        .WB_we(WB_we), .WB_dst_reg(WB_dst_reg), .WB_data(WB_data), .WB_hlt(WB_hlt),
        .bus_err(bus_err)
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  dst;
        logic [31:0] data;
        logic        hlt;
    } wb_t;

    wb_t sb[$];

    typedef struct {
        string       name;
        logic        mem_we, mem_sel, pc_sel, wb_we, mov_sel;
        logic [4:0]  dst;
        logic [31:0] mov, alu, sw;
        logic [21:0] pc;
        logic        ack;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic mem_we, input logic mem_sel, input logic pc_sel,
                          input logic wb_we, input logic mov_sel, input logic hlt,
                          input logic [4:0] dst, input logic [31:0] mov, input logic [31:0] alu,
                          input logic [31:0] sw, input logic [21:0] pc);
        MEM_mem_we = mem_we; MEM_wb_mem_sel = mem_sel; MEM_wb_pc_sel = pc_sel;
        MEM_wb_we = wb_we; MEM_wb_mov_sel = mov_sel; MEM_hlt = hlt;
        MEM_dst_reg = dst; MEM_mov_data = mov; MEM_alu_data = alu;
        MEM_sw_data = sw; MEM_wb_pc_data = pc;
    endtask

    task automatic clear_in();
        set_in(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 22'h0);
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
    endtask

    task automatic push_exp(input logic we, input logic [4:0] dst, input logic [31:0] data,
                            input logic hlt);
        wb_t e;
        e.we = we; e.dst = dst; e.data = data; e.hlt = hlt;
        sb.push_back(e);
    endtask

    task automatic retire(input string name);
        wb_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            chk({name, ".WB_we"}, {31'b0, WB_we}, {31'b0, e.we});
            chk({name, ".WB_dst_reg"}, {27'b0, WB_dst_reg}, {27'b0, e.dst});
            chk({name, ".WB_data"}, WB_data, e.data);
            chk({name, ".WB_hlt"}, {31'b0, WB_hlt}, {31'b0, e.hlt});
            $display("TXN %s we=%0b dst=%0d data=%h hlt=%0b", name, WB_we, WB_dst_reg, WB_data, WB_hlt);
        end
    endtask

    task automatic bubble(input string name);
        chk({name, ".bubble_we"}, {31'b0, WB_we}, 32'h0);
        chk({name, ".bubble_hlt"}, {31'b0, WB_hlt}, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_in();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input string name, input logic mem_we, input logic mem_sel,
                                input logic pc_sel, input logic wb_we, input logic mov_sel,
                                input logic [4:0] dst, input logic [31:0] mov, input logic [31:0] alu,
                                input logic [31:0] sw, input logic [21:0] pc, input logic ack,
                                input logic [31:0] rdata, input logic exp_req,
                                input logic [31:0] exp_data);
        vec_t v;
        v.name = name; v.mem_we = mem_we; v.mem_sel = mem_sel; v.pc_sel = pc_sel;
        v.wb_we = wb_we; v.mov_sel = mov_sel; v.dst = dst; v.mov = mov; v.alu = alu;
        v.sw = sw; v.pc = pc; v.ack = ack; v.rdata = rdata; v.exp_req = exp_req;
        v.exp_data = exp_data;
        return v;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_in();
        #2;
        chk("reset.WB_we", {31'b0, WB_we}, 32'h0);
        chk("reset.WB_data", WB_data, 32'h0);
        chk("reset.WB_hlt", {31'b0, WB_hlt}, 32'h0);
        chk("reset.bus_err", {31'b0, bus_err}, 32'h0);
        chk("reset.dmem_req", {31'b0, dmem_req}, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        //                name       mw ms ps we mv dst   mov           alu           sw            pc          ack rdata         req exp_data
        vecs[0] = mk("alu",        0, 0, 0, 1, 0, 5'd5, 32'h0,        32'h0000_1234, 32'h0,        22'h0,       0, 32'h0,        0, 32'h0000_1234);
        vecs[1] = mk("store0ws",   1, 0, 0, 0, 0, 5'd7, 32'h0,        32'h0000_0010, 32'hA5A5_A5A5, 22'h0,      1, 32'hFFFF_FFFF, 1, 32'h0000_0010);
        vecs[2] = mk("pcwb",       0, 0, 1, 1, 0, 5'd9, 32'h0,        32'h1111_1111, 32'h0,        22'h3F_FFFF, 0, 32'h0,        0, 32'h003F_FFFF);
        vecs[3] = mk("movpc",      0, 0, 1, 1, 1, 5'd10, 32'hCAFE_0001, 32'h2222_2222, 32'h0,      22'h12_3456, 0, 32'h0,        0, 32'hCAFE_0001);
        vecs[4] = mk("load0ws",    0, 1, 0, 1, 0, 5'd11, 32'h0,       32'h0000_0020, 32'h0,        22'h0,       1, 32'h1122_3344, 1, 32'h1122_3344);
        vecs[5] = mk("loadmov",    0, 1, 0, 1, 1, 5'd12, 32'h5555_5555, 32'h0000_0024, 32'h0,     22'h0,       1, 32'h9988_7766, 1, 32'h9988_7766);
        vecs[6] = mk("alu_nowe",   0, 0, 0, 0, 0, 5'd13, 32'h0,       32'h0BAD_F00D, 32'h0,        22'h0,       0, 32'h0,        0, 32'h0BAD_F00D);

        for (int i = 0; i < 7; i++) begin
            set_in(vecs[i].mem_we, vecs[i].mem_sel, vecs[i].pc_sel, vecs[i].wb_we, vecs[i].mov_sel, 1'b0,
                   vecs[i].dst, vecs[i].mov, vecs[i].alu, vecs[i].sw, vecs[i].pc);
            dmem_ack = vecs[i].ack;
            dmem_rdata = vecs[i].rdata;
            push_exp(vecs[i].wb_we, vecs[i].dst, vecs[i].exp_data, 1'b0);
            #3;
            chk({vecs[i].name, ".dmem_req"}, {31'b0, dmem_req}, {31'b0, vecs[i].exp_req});
            chk({vecs[i].name, ".mem_stall"}, {31'b0, mem_stall}, 32'h0);
            if (vecs[i].exp_req) begin
                chk({vecs[i].name, ".dmem_we"}, {31'b0, dmem_we}, {31'b0, vecs[i].mem_we});
                chk({vecs[i].name, ".dmem_addr"}, {16'b0, dmem_addr}, {16'b0, vecs[i].alu[15:0]});
                if (vecs[i].mem_we)
                    chk({vecs[i].name, ".dmem_wdata"}, dmem_wdata, vecs[i].sw);
            end
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            retire(vecs[i].name);
        end
        chk("no_err_after_table", {31'b0, bus_err}, 32'h0);

        // Load acked on the fourth request cycle.
        set_in(0, 1, 0, 1, 0, 0, 5'd14, 32'h0, 32'h0000_0040, 32'h0, 22'h0);
        push_exp(1'b1, 5'd14, 32'hDEAD_BEEF, 1'b0);
        for (int k = 0; k < 4; k++) begin
            dmem_ack = (k == 3);
            dmem_rdata = (k == 3) ? 32'hDEAD_BEEF : 32'hBAD0_0000;
            #3;
            chk($sformatf("load3.req%0d", k), {31'b0, dmem_req}, 32'h1);
            chk($sformatf("load3.stall%0d", k), {31'b0, mem_stall}, {31'b0, (k < 3)});
            if (k == 0) chk("load3.addr", {16'b0, dmem_addr}, 32'h0000_0040);
            @(posedge clk); #1;
            if (k < 3) bubble($sformatf("load3.c%0d", k));
            else retire("load3");
        end
        dmem_ack = 1'b0;

        // Load that never gets an ack: aborted on the 15th WAIT cycle.
        set_in(0, 1, 0, 1, 0, 0, 5'd15, 32'h0, 32'h0000_0080, 32'h0, 22'h0);
        dmem_rdata = 32'h7777_7777;
        push_exp(1'b1, 5'd15, 32'h0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            #3;
            chk($sformatf("tmo.req%0d", k), {31'b0, dmem_req}, 32'h1);
            chk($sformatf("tmo.stall%0d", k), {31'b0, mem_stall}, {31'b0, (k < 15)});
            @(posedge clk); #1;
            if (k < 15) begin
                bubble($sformatf("tmo.c%0d", k));
                if (k == 14) chk("tmo.bus_err_before", {31'b0, bus_err}, 32'h0);
            end else begin
                retire("timeout_load");
            end
        end
        chk("tmo.bus_err", {31'b0, bus_err}, 32'h1);
        set_in(0, 0, 0, 1, 0, 0, 5'd2, 32'h0, 32'h0000_00AA, 32'h0, 22'h0);
        push_exp(1'b1, 5'd2, 32'h0000_00AA, 1'b0);
        #3;
        chk("after_tmo.req", {31'b0, dmem_req}, 32'h0);
        @(posedge clk); #1;
        retire("after_tmo");
        chk("tmo.bus_err_sticky", {31'b0, bus_err}, 32'h1);

        do_reset();
        chk("reset2.bus_err", {31'b0, bus_err}, 32'h0);

        // Halt, then a load that must be suppressed.
        set_in(0, 0, 0, 0, 0, 1, 5'd0, 32'h0, 32'h0000_0001, 32'h0, 22'h0);
        push_exp(1'b0, 5'd0, 32'h0000_0001, 1'b1);
        @(posedge clk); #1;
        retire("halt");
        set_in(0, 1, 0, 1, 0, 0, 5'd20, 32'h0, 32'h0000_0050, 32'h0, 22'h0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1234_5678;
        push_exp(1'b0, 5'd20, 32'h0, 1'b0);
        #3;
        chk("halted_load.req", {31'b0, dmem_req}, 32'h0);
        chk("halted_load.stall", {31'b0, mem_stall}, 32'h0);
        @(posedge clk); #1;
        retire("halted_load");
        set_in(0, 0, 0, 1, 0, 1, 5'd21, 32'h0, 32'h0000_0099, 32'h0, 22'h0);
        dmem_ack = 1'b0;
        push_exp(1'b0, 5'd21, 32'h0000_0099, 1'b0);
        @(posedge clk); #1;
        retire("halted_hlt");

        do_reset();

        // Reset arriving while a load sits in WAIT.
        set_in(0, 0, 0, 1, 0, 0, 5'd3, 32'h0, 32'h0000_0077, 32'h0, 22'h0);
        push_exp(1'b1, 5'd3, 32'h0000_0077, 1'b0);
        @(posedge clk); #1;
        retire("pre_rst_alu");
        set_in(0, 1, 0, 1, 0, 0, 5'd4, 32'h0, 32'h0000_0060, 32'h0, 22'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midwait.req_before", {31'b0, dmem_req}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("midwait.req", {31'b0, dmem_req}, 32'h0);
        chk("midwait.stall", {31'b0, mem_stall}, 32'h0);
        chk("midwait.WB_we", {31'b0, WB_we}, 32'h0);
        chk("midwait.WB_dst", {27'b0, WB_dst_reg}, 32'h0);
        chk("midwait.WB_data", WB_data, 32'h0);
        chk("midwait.WB_hlt", {31'b0, WB_hlt}, 32'h0);
        chk("midwait.bus_err", {31'b0, bus_err}, 32'h0);
        clear_in();
        @(posedge clk); #1;
        rst = 1'b0;
        #3;
        chk("post_rst.req", {31'b0, dmem_req}, 32'h0);

        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
